// File: rtl/arm_shift_pkg.sv
// Shared encodings and operand decode for the iterative ARM shifter-operand unit.
package arm_shift_pkg;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // rrx marks a ROR #0 in register form: one step that feeds the latched C in at bit 31.
   typedef struct packed {
      logic [31:0] dat;
      logic [1:0]  sh_type;
      logic        rrx;
      logic [5:0]  cnt;
   } shift_op_t;

   function automatic shift_op_t decode_op(input logic        imm_sel,
                                           input logic [11:0] operand,
                                           input logic [31:0] rm);
      shift_op_t  op;
      logic [4:0] imm5;
      imm5       = operand[11:7];
      op.dat     = rm;
      op.sh_type = operand[6:5];
      op.rrx     = 1'b0;
      op.cnt     = {1'b0, imm5};
      if (imm_sel) begin
         op.dat     = {24'b0, operand[7:0]};
         op.sh_type = SH_ROR;
         op.cnt     = {1'b0, operand[11:8], 1'b0};
      end else if (imm5 == 5'd0) begin
         // A zero amount re-encodes LSR/ASR as #32 and ROR as RRX.
         case (operand[6:5])
            SH_LSL:         op.cnt = 6'd0;
            SH_LSR, SH_ASR: op.cnt = 6'd32;
            default: begin
               op.rrx = 1'b1;
               op.cnt = 6'd1;
            end
         endcase
      end
      return op;
   endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step with the bit shifted out.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module shift_step
   import arm_shift_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  sh_type,
   input  logic        rrx,
   input  logic        c_in,
   output logic [31:0] next,
   output logic        shifted_out
);

   always_comb begin
      next        = data;
      shifted_out = 1'b0;
      if (rrx) begin
         next        = {c_in, data[31:1]};
         shifted_out = data[0];
      end else begin
         case (sh_type)
            SH_LSL: begin
               next        = {data[30:0], 1'b0};
               shifted_out = data[31];
            end
            SH_LSR: begin
               next        = {1'b0, data[31:1]};
               shifted_out = data[0];
            end
            SH_ASR: begin
               next        = {data[31], data[31:1]};
               shifted_out = data[0];
            end
            default: begin
               // After a one-bit rotate the carry equals the new bit 31.
               next        = {data[0], data[31:1]};
               shifted_out = data[0];
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative ARM shifter-operand unit: decode, then one shift/rotate bit per clock.
// Latency: N+1 cycles from the start cycle to the done pulse (N = effective shift count).
// Backpressure: start accepted only while ready; ignored in SHIFT/DONE, no queuing.
module shift_sequencer
   import arm_shift_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        imm_sel,
   input  logic [11:0] shifter_operand,
   input  logic [31:0] rm,
   input  logic        c_in,
   output logic        ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        carry_out
);

   state_t      state;
   shift_op_t   op_q;
   shift_op_t   op_dec;
   logic        cin_q;
   logic [31:0] step_next;
   logic        step_out;

   assign op_dec = decode_op(imm_sel, shifter_operand, rm);

   shift_step u_step (
      .data        (op_q.dat),
      .sh_type     (op_q.sh_type),
      .rrx         (op_q.rrx),
      .c_in        (cin_q),
      .next        (step_next),
      .shifted_out (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         cin_q     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         done      <= 1'b0;
         ready     <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_q  <= op_dec;
                  cin_q <= c_in;
                  ready <= 1'b0;
                  if (op_dec.cnt == 6'd0) begin
                     state     <= ST_DONE;
                     result    <= op_dec.dat;
                     carry_out <= c_in;
                     done      <= 1'b1;
                  end else begin
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               op_q.dat <= step_next;
               op_q.cnt <= op_q.cnt - 6'd1;
               // Outputs load with the final step so they are valid alongside done.
               if (op_q.cnt == 6'd1) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  result    <= step_next;
                  carry_out <= step_out;
                  done      <= 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed-vector bench for shift_sequencer with a queue-based scoreboard.
// Latency: expectations carry the start cycle; the monitor checks done-to-start distance.
// Backpressure: stimulus waits for ready before each start.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        imm_sel;
   logic [11:0] shifter_operand;
   logic [31:0] rm;
   logic        c_in;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        carry_out;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        car;
      int          lat;
      int          t0;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   shift_sequencer dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .imm_sel         (imm_sel),
      .shifter_operand (shifter_operand),
      .rm              (rm),
      .c_in            (c_in),
      .ready           (ready),
      .busy            (busy),
      .done            (done),
      .result          (result),
      .carry_out       (carry_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic issue(input string name, input logic isel, input logic [11:0] op,
                        input logic [31:0] r, input logic ci,
                        input logic [31:0] exp_res, input logic exp_car, input int lat);
      exp_t e;
      int   waited = 0;
      @(negedge clk);
      while (!ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check({name, "_ready_wait"}, 32'(ready), 32'd1);
      if (!ready) return;
      imm_sel         = isel;
      shifter_operand = op;
      rm              = r;
      c_in            = ci;
      start           = 1'b1;
      e.name = name;
      e.res  = exp_res;
      e.car  = exp_car;
      e.lat  = lat;
      e.t0   = cyc;
      q.push_back(e);
      @(negedge clk);
      start           = 1'b0;
      imm_sel         = ~isel;
      shifter_operand = ~op;
      rm              = ~r;
      c_in            = ~ci;
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            check("done_vs_ready", 32'(ready), 32'd0);
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done with result %h, want no done", result);
            end else begin
               e = q.pop_front();
               check({e.name, "_result"}, result, e.res);
               check({e.name, "_carry"}, 32'(carry_out), 32'(e.car));
               check({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no end of run, want completion");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      rst_n = 1'b0; start = 1'b0; imm_sel = 1'b0;
      shifter_operand = '0; rm = '0; c_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_carry", 32'(carry_out), 32'd0);
      rst_n = 1'b1;

      issue("imm_1ff",  1'b1, 12'h1FF, 32'h0,          1'b0, 32'hC000_003F, 1'b1, 3);
      issue("lsl0",     1'b0, 12'h000, 32'h8000_0001,  1'b1, 32'h8000_0001, 1'b1, 1);
      issue("imm_rot0", 1'b1, 12'h0AB, 32'h0,          1'b1, 32'h0000_00AB, 1'b1, 1);
      issue("lsr32",    1'b0, 12'h020, 32'h8000_0000,  1'b0, 32'h0,         1'b1, 33);
      issue("rrx",      1'b0, 12'h060, 32'h0000_0003,  1'b1, 32'h8000_0001, 1'b1, 2);
      issue("ror8",     1'b0, 12'h460, 32'h1234_5678,  1'b1, 32'h7812_3456, 1'b0, 9);
      issue("asr1",     1'b0, 12'h0C0, 32'h8000_0001,  1'b0, 32'hC000_0000, 1'b1, 2);
      issue("lsr1",     1'b0, 12'h0A0, 32'h8000_0001,  1'b0, 32'h4000_0000, 1'b1, 2);
      issue("lsl31",    1'b0, 12'hF80, 32'h0000_0003,  1'b0, 32'h8000_0000, 1'b1, 32);
      issue("imm_rot30",1'b1, 12'hF01, 32'h0,          1'b1, 32'h0000_0004, 1'b0, 31);

      // Start pulsed mid-SHIFT with different inputs must be ignored.
      issue("lsl4",     1'b0, 12'h200, 32'h0000_0001,  1'b0, 32'h0000_0010, 1'b0, 5);
      check("lsl4_busy", 32'(busy), 32'd1);
      imm_sel = 1'b1; shifter_operand = 12'hFFF; rm = 32'hDEAD_BEEF; c_in = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      issue("asr32",    1'b0, 12'h040, 32'h8000_0000,  1'b0, 32'hFFFF_FFFF, 1'b1, 33);

      // Abort an LSR #20 in its third cycle; its expectation is withdrawn.
      issue("lsr20",    1'b0, 12'hA20, 32'hFFFF_FFFF,  1'b0, 32'h0000_0FFF, 1'b1, 21);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_result", result, 32'd0);
      check("abort_carry", 32'(carry_out), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(ready), 32'd1);
      issue("after_rst", 1'b1, 12'h1FF, 32'h0,          1'b0, 32'hC000_003F, 1'b1, 3);

      w = 0;
      while (q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("queue_drained", 32'(q.size()), 32'd0);
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller for the ARM data-processing shifter operand in the Phase 2 datapath. On a start pulse it decodes a 12-bit shifter_operand field (32-bit rotated immediate, or register Rm shifted by a 5-bit immediate), captures its inputs, and performs the shift or rotate one bit position per clock. It then reports the shifter result and shifter carry-out with a one-cycle done pulse. It sits between the instruction decode/control unit and the ALU operand-B input, replacing the combinational shifter path where timing requires.

## Interface
- No parameters; the data width is fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- imm_sel  in  1  1 = immediate form (operand[11:8] rotate, operand[7:0] value); 0 = Rm shifted by immediate
- shifter_operand  in  12  instruction bits [11:0]
- rm  in  32  register operand Rm
- c_in  in  1  current CPSR C flag
- ready  out  1  high in IDLE
- busy  out  1  high in SHIFT
- done  out  1  one-cycle pulse; result and carry_out are valid from this cycle on
- result  out  32  shifter_operand value
- carry_out  out  1  shifter carry-out

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset enters IDLE and clears result, carry_out and done to 0.
- In IDLE, when start=1 the block latches data, shift type, effective count N and carry.
- Immediate form (imm_sel=1):
  - data = {24'b0, operand[7:0]}; type = ROR; N = 2*operand[11:8] (range 0..30).
  - carry = c_in.
- Register form (imm_sel=0): data = rm; imm5 = operand[11:7]; type = operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - LSL #0: N=0, carry=c_in.
  - LSR #0 means LSR #32, so N=32.
  - ASR #0 means ASR #32, so N=32.
  - ROR #0 means RRX: N=1, and the single step inserts the latched c_in at bit 31.
  - Otherwise N = imm5.
- Latch transitions: N=0 goes to DONE; N>0 goes to SHIFT with cnt=N.
- SHIFT, each cycle:
  - Apply one step: the shift_step function returns the next data and the bit shifted out, and that bit is written to carry.
  - cnt decrements; when cnt==1 before the decrement, the next state is DONE.
- Step rules:
  - LSL shifts in 0; carry = data[31].
  - LSR shifts in 0; carry = data[0].
  - ASR shifts in data[31]; carry = data[0].
  - ROR rotates; carry = data[0] after rotation (the new bit 31).
  - RRX shifts in the latched c_in; carry = old data[0].
- Immediate ROR with N>0 therefore ends with carry = result[31]. A 32-step LSR yields 0 with carry = rm[31]. A 32-step ASR yields all copies of rm[31].
- DONE: done=1; result and carry_out are updated from the internal registers on entry. Next state is always IDLE.
- result and carry_out hold until the next DONE; they do not change during SHIFT.
- start is ignored while in SHIFT or DONE (no queuing). Input changes after acceptance have no effect.
- rst_n low at any time aborts the operation asynchronously and returns the block to the reset state. No done pulse is produced for the aborted operation.

## Timing
- Start sampled at edge 0; DONE is the state after edge N+1. Latency is N+1 cycles: 1 for N=0, 2 for RRX, 33 for LSR/ASR #32.
- ready=0 for N+1 cycles after acceptance, and ready=1 again in the cycle after done.
- The minimum start-to-start spacing is N+2 cycles.
- done is registered (state-decoded), is exactly one cycle wide, and is never asserted in the same cycle as ready.

## Structure
- Package arm_shift_pkg:
  - shift type encoding constants SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11;
  - an internal RRX flag;
  - the FSM state encoding for IDLE, SHIFT and DONE.
- Sub-module shift_step: combinational single-bit step with inputs data[31:0], type, rrx and c_in, and outputs next[31:0] and shifted_out. It is reusable by other iterative units.
- The top-level module holds the FSM, the 6-bit counter (range 0..32), the operand decode and the output registers.

## Test plan
- Immediate: imm_sel=1, operand=12'h1FF, c_in=0 → done 3 cycles after start; result=32'hC000003F; carry_out=1.
- LSL #0: imm_sel=0, operand=12'h000, rm=32'h8000_0001, c_in=1 → done after 1 cycle; result=32'h8000_0001; carry_out=1.
- LSR #32 / ASR #32: rm=32'h8000_0000, operand=12'h020 → result=0, carry_out=1 after 33 cycles. Repeating with operand=12'h040 → result=32'hFFFF_FFFF, carry_out=1.
- RRX: operand=12'h060, rm=32'h0000_0003, c_in=1 → done after 2 cycles; result=32'h8000_0001; carry_out=1.
- Busy/ignore: LSL #4 (operand=12'h200) on rm=32'h1 → during SHIFT, pulse start with different inputs → no effect; result=32'h10; carry_out=0; exactly one done pulse.
- Reset mid-operation: drive rst_n low during cycle 3 of an LSR #20 → outputs go to 0 immediately; ready=1 after reset release; no done pulse; a new start then completes normally.
